// File: rtl/score_sender_if.sv
// score_sender_if: control, UART and SRAM handshake signals of the score sender.
// The tri-stated SRAM address/read-request lines are not part of this bundle;
// they stay plain ports on score_sender so they resolve directly on the shared bus.
interface score_sender_if #(
    parameter int MAX_WORDS = 256,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 21
);
    localparam int IDX_W = $clog2(MAX_WORDS + 1);

    // host/scorer request side
    logic              start_send;
    logic [IDX_W-1:0]  n_words;
    logic [ADDR_W-1:0] base_addr;
    logic              send_done;
    logic              busy;
    logic [2:0]        sender_state;

    // UART transmitter side
    logic              uart_ready;
    logic [7:0]        tx_byte;
    logic              start_tx;

    // SRAM read-data side
    logic [DATA_W-1:0] data_in;
    logic              sram_ready;
    logic              sram_idle;

    // the sender itself
    modport master (
        input  start_send, n_words, base_addr, uart_ready, data_in, sram_ready, sram_idle,
        output tx_byte, start_tx, send_done, busy, sender_state
    );

    // the environment around the sender (requester, UART, SRAM)
    modport slave (
        output start_send, n_words, base_addr, uart_ready, data_in, sram_ready, sram_idle,
        input  tx_byte, start_tx, send_done, busy, sender_state
    );
endinterface

// File: rtl/score_sender.sv
// score_sender: reads n_words SRAM words starting at base_addr (stepping by
// ADDR_STRIDE) and streams each word MSB-first as bytes to a UART transmitter.
// Optional feature macro: SEND_CHECKSUM_EN appends a mod-256 sum trailer byte.
module score_sender #(
    parameter int MAX_WORDS   = 256,
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 21,
    parameter int ADDR_STRIDE = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    score_sender_if.master    bus,
    output wire  [ADDR_W-1:0] data_addr,
    output wire               read_data
);
    localparam int IDX_W  = $clog2(MAX_WORDS + 1);
    localparam int NBYTES = DATA_W / 8;
    localparam int BC_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAITING = 3'd1,
        READING = 3'd2,
        TX_BYTE = 3'd3,
        TX_HOLD = 3'd4,
        CSUM    = 3'd5
    } state_t;

    state_t            state_q;
    logic [IDX_W-1:0]  n_words_q;
    logic [IDX_W-1:0]  idx_q;
    logic [ADDR_W-1:0] addr_q;      // running word address, base + idx*stride
    logic [DATA_W-1:0] shreg_q;     // word being serialised, next byte on top
    logic [BC_W-1:0]   byte_cnt_q;  // bytes already sent from the current word
    logic [7:0]        tx_byte_q;
    logic              start_tx_q;
    logic              send_done_q;
`ifdef SEND_CHECKSUM_EN
    logic [7:0]        csum_q;
    logic              csum_sent_q;
`endif

    logic [IDX_W-1:0]  idx_d;
    logic [ADDR_W-1:0] addr_d;
    logic              last_byte;
    logic              more_words;

    // Address advances by stride each word and wraps modulo 2^ADDR_W.
    assign idx_d      = idx_q + 1'b1;
    assign addr_d     = addr_q + ADDR_W'(ADDR_STRIDE);
    assign last_byte  = (byte_cnt_q == BC_W'(NBYTES - 1));
    assign more_words = (idx_d < n_words_q);

    // Transfer sequencer: all state and output registers in one place.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            n_words_q   <= '0;
            idx_q       <= '0;
            addr_q      <= '0;
            shreg_q     <= '0;
            byte_cnt_q  <= '0;
            tx_byte_q   <= 8'h00;
            start_tx_q  <= 1'b0;
            send_done_q <= 1'b0;
`ifdef SEND_CHECKSUM_EN
            csum_q      <= 8'h00;
            csum_sent_q <= 1'b0;
`endif
        end else begin
            start_tx_q  <= 1'b0;
            send_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start_send) begin
                        n_words_q  <= bus.n_words;
                        addr_q     <= bus.base_addr;
                        idx_q      <= '0;
                        byte_cnt_q <= '0;
`ifdef SEND_CHECKSUM_EN
                        csum_q      <= 8'h00;
                        csum_sent_q <= 1'b0;
`endif
                        if (bus.n_words == '0) begin
`ifdef SEND_CHECKSUM_EN
                            state_q <= CSUM;
`else
                            send_done_q <= 1'b1;
`endif
                        end else if (bus.sram_idle) begin
                            state_q <= READING;
                        end else begin
                            state_q <= WAITING;
                        end
                    end
                end
                WAITING: begin
                    if (bus.sram_idle) begin
                        state_q <= READING;
                    end
                end
                READING: begin
                    if (bus.sram_ready) begin
                        shreg_q    <= bus.data_in;
                        byte_cnt_q <= '0;
                        state_q    <= TX_BYTE;
                    end
                end
                TX_BYTE: begin
                    if (bus.uart_ready) begin
                        tx_byte_q  <= shreg_q[DATA_W-1 -: 8];
                        start_tx_q <= 1'b1;
`ifdef SEND_CHECKSUM_EN
                        csum_q     <= csum_q + shreg_q[DATA_W-1 -: 8];
`endif
                        state_q    <= TX_HOLD;
                    end
                end
                TX_HOLD: begin
                    // Guard cycle: the UART ready flag is not looked at here.
                    if (!last_byte) begin
                        shreg_q    <= shreg_q << 8;
                        byte_cnt_q <= byte_cnt_q + 1'b1;
                        state_q    <= TX_BYTE;
                    end else if (more_words) begin
                        // The bus stays ours for the whole transfer: no idle recheck.
                        idx_q   <= idx_d;
                        addr_q  <= addr_d;
                        state_q <= READING;
`ifdef SEND_CHECKSUM_EN
                    end else if (!csum_sent_q) begin
                        state_q <= CSUM;
`endif
                    end else begin
                        state_q     <= IDLE;
                        send_done_q <= 1'b1;
                    end
                end
`ifdef SEND_CHECKSUM_EN
                CSUM: begin
                    // The trailer reuses the byte path as a one-byte word.
                    shreg_q     <= DATA_W'(csum_q) << (DATA_W - 8);
                    byte_cnt_q  <= BC_W'(NBYTES - 1);
                    csum_sent_q <= 1'b1;
                    state_q     <= TX_BYTE;
                end
`endif
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Shared SRAM bus: released in IDLE, driven low except while reading.
    assign read_data = (state_q == IDLE) ? 1'bz : (state_q == READING);
    assign data_addr = (state_q == IDLE)    ? {ADDR_W{1'bz}} :
                       (state_q == READING) ? addr_q : '0;

    assign bus.tx_byte      = tx_byte_q;
    assign bus.start_tx     = start_tx_q;
    assign bus.send_done    = send_done_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.sender_state = state_q;
endmodule

// File: tb/tb_score_sender.sv
// tb_score_sender: directed tests for score_sender, with a cycle-driven SRAM
// responder and UART capture inside run_xfer.
module tb_score_sender;
    localparam int ADDR_W = 21;
    localparam int DATA_W = 16;
`ifdef SEND_CHECKSUM_EN
    localparam int CSUM_N = 1;
`else
    localparam int CSUM_N = 0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    wire [ADDR_W-1:0] data_addr;
    wire              read_data;

    score_sender_if #(.MAX_WORDS(256), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    score_sender #(.MAX_WORDS(256), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ADDR_STRIDE(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .data_addr (data_addr),
        .read_data (read_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [15:0]       sram_words [0:7];
    logic [7:0]        cap_bytes [0:15];
    logic [ADDR_W-1:0] cap_addr [0:15];
    int cap_n, addr_n, done_cnt, first_rd, first_rdy, first_tx;
    bit b2b_err;

    task automatic start_pulse(input int n, input logic [ADDR_W-1:0] base);
        @(negedge clk);
        bus.n_words    = 9'(n);
        bus.base_addr  = base;
        bus.start_send = 1'b1;
    endtask

    // Runs the environment cycle by cycle: answers reads, captures UART bytes.
    task automatic run_xfer(input int max_cycles, input int poke_at, output bit finished);
        int word;
        bit responded;
        bit prev_tx;
        int tail;
        finished = 0; word = 0; responded = 0; prev_tx = 0; tail = 0;
        cap_n = 0; addr_n = 0; done_cnt = 0; b2b_err = 0;
        first_rd = -1; first_rdy = -1; first_tx = -1;
        for (int c = 0; c < max_cycles; c++) begin
            @(negedge clk);
            bus.start_send = 1'b0;
            bus.sram_ready = 1'b0;
            if (c == poke_at) begin
                bus.start_send = 1'b1;
                bus.n_words    = 9'd1;
                bus.base_addr  = 21'h000200;
            end
            if (read_data === 1'b1) begin
                if (first_rd < 0) first_rd = c;
                if (!responded) begin
                    if (addr_n < 16) cap_addr[addr_n] = data_addr;
                    addr_n++;
                    bus.data_in    = sram_words[word % 8];
                    word++;
                    bus.sram_ready = 1'b1;
                    responded      = 1;
                    if (first_rdy < 0) first_rdy = c;
                end
            end else begin
                responded = 0;
            end
            if (bus.start_tx === 1'b1) begin
                if (prev_tx) b2b_err = 1;
                if (first_tx < 0) first_tx = c;
                if (cap_n < 16) cap_bytes[cap_n] = bus.tx_byte;
                cap_n++;
            end
            prev_tx = (bus.start_tx === 1'b1);
            if (bus.send_done === 1'b1) begin
                done_cnt++;
                finished = 1;
            end
            if (finished) begin
                tail++;
                if (tail > 3) break;
            end
        end
        $display("xfer: words_read=%0d bytes=%0d done_pulses=%0d", addr_n, cap_n, done_cnt);
    endtask

    task automatic test_reset();
        bus.start_send = 0; bus.n_words = '0; bus.base_addr = '0; bus.uart_ready = 1;
        bus.data_in = '0; bus.sram_ready = 0; bus.sram_idle = 1;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.sender_state !== 3'd0) begin failures++; $display("FAIL reset_state: got %0d want 0", bus.sender_state); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.start_tx !== 1'b0 || bus.send_done !== 1'b0) begin failures++; $display("FAIL reset_strobes: start_tx=%b send_done=%b want 0/0", bus.start_tx, bus.send_done); end
        checks++; if (bus.tx_byte !== 8'h00) begin failures++; $display("FAIL reset_tx_byte: got %h want 00", bus.tx_byte); end
        checks++; if (read_data === 1'b1) begin failures++; $display("FAIL reset_read_data: got %b want released", read_data); end
        reset_n = 1'b1;
        $display("reset: done");
    endtask

    task automatic test_basic();
        logic [7:0] exp_b [0:7];
        int exp_n;
        bit fin;
        exp_b = '{8'h12, 8'h34, 8'hFF, 8'h80, 8'h00, 8'h01, 8'hC6, 8'h00};
        exp_n = 6 + CSUM_N;
        sram_words = '{16'h1234, 16'hFF80, 16'h0001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        bus.sram_idle = 1; bus.uart_ready = 1;
        start_pulse(3, 21'h000100);
        run_xfer(300, -1, fin);
        checks++; if (!fin) begin failures++; $display("FAIL basic_timeout: send_done not seen"); end
        checks++; if (first_rd !== 0) begin failures++; $display("FAIL basic_read_latency: got %0d want 0", first_rd); end
        checks++; if (first_tx - first_rdy !== 2) begin failures++; $display("FAIL basic_ready_to_tx: got %0d want 2", first_tx - first_rdy); end
        checks++; if (addr_n !== 3) begin failures++; $display("FAIL basic_word_count: got %0d want 3", addr_n); end
        checks++; if (cap_addr[0] !== 21'h100 || cap_addr[1] !== 21'h102 || cap_addr[2] !== 21'h104) begin
            failures++; $display("FAIL basic_addr: got %h %h %h want 100 102 104", cap_addr[0], cap_addr[1], cap_addr[2]);
        end
        checks++; if (cap_n !== exp_n) begin failures++; $display("FAIL basic_byte_count: got %0d want %0d", cap_n, exp_n); end
        for (int i = 0; i < exp_n; i++) begin
            checks++; if (cap_bytes[i] !== exp_b[i]) begin failures++; $display("FAIL basic_byte%0d: got %h want %h", i, cap_bytes[i], exp_b[i]); end
        end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL basic_done_pulses: got %0d want 1", done_cnt); end
        checks++; if (b2b_err !== 1'b0) begin failures++; $display("FAIL basic_spacing: start_tx high two cycles in a row"); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL basic_busy_after: got %b want 0", bus.busy); end
    endtask

    task automatic test_waiting();
        bit fin;
        sram_words[0] = 16'h5AA5;
        bus.sram_idle = 0;
        start_pulse(1, 21'h000040);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.start_send = 0;
            checks++; if (bus.sender_state !== 3'd1 || read_data !== 1'b0) begin
                failures++; $display("FAIL wait_cycle%0d: state=%0d read_data=%b want 1/0", i, bus.sender_state, read_data);
            end
        end
        bus.sram_idle = 1;
        @(negedge clk);
        checks++; if (bus.sender_state !== 3'd2 || read_data !== 1'b1) begin
            failures++; $display("FAIL wait_to_read: state=%0d read_data=%b want 2/1", bus.sender_state, read_data);
        end
        checks++; if (data_addr !== 21'h000040) begin failures++; $display("FAIL wait_addr: got %h want 000040", data_addr); end
        run_xfer(200, -1, fin);
        checks++; if (!fin || done_cnt !== 1 || cap_n !== 2 + CSUM_N) begin
            failures++; $display("FAIL wait_complete: fin=%b done=%0d bytes=%0d want 1/1/%0d", fin, done_cnt, cap_n, 2 + CSUM_N);
        end
        checks++; if (cap_bytes[0] !== 8'h5A || cap_bytes[1] !== 8'hA5) begin
            failures++; $display("FAIL wait_bytes: got %h %h want 5A A5", cap_bytes[0], cap_bytes[1]);
        end
    endtask

    task automatic test_uart_stall();
        logic [7:0] prev_byte;
        logic [7:0] exp_b [0:1];
        bit fin;
        prev_byte = (CSUM_N != 0) ? 8'hFF : 8'hA5;
        exp_b = '{8'hCD, 8'h78};
        sram_words[0] = 16'hABCD;
        bus.uart_ready = 0;
        start_pulse(1, 21'h000010);
        @(negedge clk);
        bus.start_send = 0;
        bus.data_in = sram_words[0];
        bus.sram_ready = 1;
        @(negedge clk);
        bus.sram_ready = 0;
        checks++; if (bus.sender_state !== 3'd3) begin failures++; $display("FAIL stall_state: got %0d want 3", bus.sender_state); end
        checks++; if (read_data !== 1'b0 || data_addr !== 21'h0) begin
            failures++; $display("FAIL stall_bus_low: read_data=%b addr=%h want 0/000000", read_data, data_addr);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++; if (bus.start_tx !== 1'b0 || bus.tx_byte !== prev_byte) begin
                failures++; $display("FAIL stall_cycle%0d: start_tx=%b tx_byte=%h want 0/%h", i, bus.start_tx, bus.tx_byte, prev_byte);
            end
        end
        bus.uart_ready = 1;
        @(negedge clk);
        checks++; if (bus.start_tx !== 1'b1 || bus.tx_byte !== 8'hAB) begin
            failures++; $display("FAIL stall_release: start_tx=%b tx_byte=%h want 1/AB", bus.start_tx, bus.tx_byte);
        end
        run_xfer(200, -1, fin);
        checks++; if (!fin || done_cnt !== 1 || cap_n !== 1 + CSUM_N) begin
            failures++; $display("FAIL stall_complete: fin=%b done=%0d bytes=%0d want 1/1/%0d", fin, done_cnt, cap_n, 1 + CSUM_N);
        end
        for (int i = 0; i < 1 + CSUM_N; i++) begin
            checks++; if (cap_bytes[i] !== exp_b[i]) begin failures++; $display("FAIL stall_byte%0d: got %h want %h", i, cap_bytes[i], exp_b[i]); end
        end
    endtask

    task automatic test_zero_words();
        bit fin;
        start_pulse(0, 21'h000300);
        run_xfer(100, -1, fin);
        checks++; if (!fin || done_cnt !== 1) begin failures++; $display("FAIL zero_done: fin=%b done=%0d want 1/1", fin, done_cnt); end
        checks++; if (cap_n !== CSUM_N || addr_n !== 0) begin
            failures++; $display("FAIL zero_activity: bytes=%0d reads=%0d want %0d/0", cap_n, addr_n, CSUM_N);
        end
        for (int i = 0; i < CSUM_N; i++) begin
            checks++; if (cap_bytes[i] !== 8'h00) begin failures++; $display("FAIL zero_csum_byte: got %h want 00", cap_bytes[i]); end
        end
    endtask

    task automatic test_reset_mid();
        bit fin;
        int dones;
        sram_words = '{16'h1234, 16'hFF80, 16'h0001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        start_pulse(3, 21'h000100);
        run_xfer(6, -1, fin);
        checks++; if (addr_n !== 2 || cap_addr[1] !== 21'h102) begin
            failures++; $display("FAIL mid_progress: reads=%0d addr=%h want 2/000102", addr_n, cap_addr[1]);
        end
        bus.sram_ready = 0;
        reset_n = 1'b0;
        #1;
        checks++; if (bus.sender_state !== 3'd0 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL mid_reset_state: state=%0d busy=%b want 0/0", bus.sender_state, bus.busy);
        end
        checks++; if (bus.tx_byte !== 8'h00 || bus.start_tx !== 1'b0 || read_data === 1'b1) begin
            failures++; $display("FAIL mid_reset_outputs: tx_byte=%h start_tx=%b read_data=%b want 00/0/released", bus.tx_byte, bus.start_tx, read_data);
        end
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.send_done === 1'b1) dones++;
        end
        reset_n = 1'b1;
        @(negedge clk);
        if (bus.send_done === 1'b1) dones++;
        checks++; if (dones !== 0) begin failures++; $display("FAIL mid_no_done: got %0d pulses want 0", dones); end
        start_pulse(3, 21'h000100);
        run_xfer(300, -1, fin);
        checks++; if (!fin || cap_addr[0] !== 21'h100 || cap_bytes[0] !== 8'h12 || cap_n !== 6 + CSUM_N) begin
            failures++; $display("FAIL mid_restart: fin=%b addr0=%h byte0=%h bytes=%0d want 1/000100/12/%0d", fin, cap_addr[0], cap_bytes[0], cap_n, 6 + CSUM_N);
        end
    endtask

    task automatic test_busy_wrap();
        logic [7:0] exp_b [0:4];
        bit fin;
        exp_b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
        sram_words = '{16'h0102, 16'h0304, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        start_pulse(2, 21'h1FFFFE);
        run_xfer(300, 3, fin);
        checks++; if (!fin || done_cnt !== 1) begin failures++; $display("FAIL wrap_done: fin=%b done=%0d want 1/1", fin, done_cnt); end
        checks++; if (addr_n !== 2 || cap_addr[0] !== 21'h1FFFFE || cap_addr[1] !== 21'h000000) begin
            failures++; $display("FAIL wrap_addr: reads=%0d got %h %h want 2 1FFFFE 000000", addr_n, cap_addr[0], cap_addr[1]);
        end
        checks++; if (cap_n !== 4 + CSUM_N) begin failures++; $display("FAIL wrap_byte_count: got %0d want %0d", cap_n, 4 + CSUM_N); end
        for (int i = 0; i < 4 + CSUM_N; i++) begin
            checks++; if (cap_bytes[i] !== exp_b[i]) begin failures++; $display("FAIL wrap_byte%0d: got %h want %h", i, cap_bytes[i], exp_b[i]); end
        end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL wrap_ignored_start: busy=%b want 0", bus.busy); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_waiting();
        test_uart_stall();
        test_zero_words();
        test_reset_mid();
        test_busy_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
